// File: rtl/block_result_unloader.sv
// block_result_unloader
// Drain side of the block multiplier datapath. The compute stage fills a
// local N-entry buffer through an addressed write port and then pulses commit.
// The block then streams the words out in index order on a valid/ready port
// and pulses done after the final beat has been accepted.
//
// Optional feature: define UNLOAD_CHECKSUM_EN to append one extra beat after
// the N elements. That beat carries the sum of the streamed elements modulo
// 2^BIT_W. With the macro undefined the block streams exactly N beats.
module block_result_unloader #(
  parameter int BIT_W = 16,
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [BIT_W-1:0] wr_data,
  input  logic             commit,
  output logic [BIT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             wr_err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

`ifdef UNLOAD_CHECKSUM_EN
  localparam int BEATS = N + 1;
`else
  localparam int BEATS = N;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready.
  // Once out_valid is high, out_data/out_last/idx hold until that transfer,
  // and out_valid only drops after the last beat transfers (or on reset).

  logic [0:0]       state;   // FSM state; busy is its external view
  logic [IDX_W-1:0] idx;
  logic [BIT_W-1:0] mem [N];
  logic             addr_ok;
  logic             wr_ok;
  logic             xfer;

  assign addr_ok   = (wr_addr < N_IDX);
  assign wr_ok     = wr_en && addr_ok && (state == S_IDLE);
  assign out_valid = (state == S_STREAM);
  assign busy      = (state == S_STREAM);
  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid && (idx == LAST_IDX);

  // Buffer write port: only open in IDLE, so the buffer is frozen while streaming.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Control FSM: IDLE waits for commit, STREAM walks idx one beat per transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      done   <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en && ((state == S_STREAM) || !addr_ok);
      case (state)
        S_IDLE: begin
          if (commit) begin
            state <= S_STREAM;
            idx   <= '0;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              state <= S_IDLE;
              idx   <= '0;
              done  <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

`ifdef UNLOAD_CHECKSUM_EN
  logic [BIT_W-1:0] acc;

  // Running sum of data beats; cleared when a new block is committed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if ((state == S_IDLE) && commit) begin
      acc <= '0;
    end else if (xfer && (idx != LAST_IDX)) begin
      acc <= acc + mem[idx];
    end
  end

  // Output mux: element beats from the buffer, final beat from the accumulator.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      if (idx == N_IDX) begin
        out_data = acc;
      end else begin
        out_data = mem[idx];
      end
    end
  end
`else
  // Output mux: current element while valid, zero otherwise.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = mem[idx];
    end
  end
`endif

endmodule

// File: tb/tb_block_result_unloader.sv
// Testbench for block_result_unloader. Every cycle the DUT outputs are
// compared with a queue-based model of the expected beat stream; directed
// sequences add explicit checks on beat contents, error pulses and done.
module tb_block_result_unloader;

  localparam int BIT_W = 16;
  localparam int N     = 10;
  localparam int IDX_W = 4;
`ifdef UNLOAD_CHECKSUM_EN
  localparam int BEATS = N + 1;
`else
  localparam int BEATS = N;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_addr = '0;
  logic [BIT_W-1:0] wr_data = '0;
  logic             commit = 1'b0;
  logic             out_ready = 1'b0;
  logic [BIT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             wr_err;

  block_result_unloader #(.BIT_W(BIT_W), .N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .wr_err(wr_err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  logic [BIT_W-1:0] model_mem [N];
  logic [BIT_W-1:0] exp_q[$];
  logic [BIT_W-1:0] got_q[$];
  logic m_done = 1'b0;
  logic m_err  = 1'b0;
  logic obs_valid, obs_busy, obs_done, obs_err;

  typedef struct {
    logic             en;
    logic [IDX_W-1:0] addr;
    logic [BIT_W-1:0] data;
    logic             exp_err;
  } wr_vec_t;
  wr_vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge with the inputs currently driven.
  task automatic model_step();
    logic streaming;
    logic nd;
    logic [BIT_W-1:0] sum;
    if (!rst_n) begin
      exp_q.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      streaming = (exp_q.size() > 0);
      nd = 1'b0;
      m_err = wr_en && (streaming || (int'(wr_addr) >= N));
      if (streaming && out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) nd = 1'b1;
      end
      if (!streaming) begin
        if (wr_en && (int'(wr_addr) < N)) model_mem[wr_addr] = wr_data;
        if (commit) begin
          sum = '0;
          for (int i = 0; i < N; i++) begin
            exp_q.push_back(model_mem[i]);
            sum = sum + model_mem[i];
          end
`ifdef UNLOAD_CHECKSUM_EN
          exp_q.push_back(sum);
`endif
        end
      end
      m_done = nd;
    end
  endtask

  // One cycle: compare at negedge, advance model, step past the posedge.
  task automatic tick();
    logic             ev;
    logic [BIT_W-1:0] ed;
    @(negedge clk);
    ev = (exp_q.size() > 0);
    ed = ev ? exp_q[0] : '0;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_data",  32'(out_data),  32'(ed));
    check("out_last",  32'(out_last),  32'(exp_q.size() == 1));
    check("busy",      32'(busy),      32'(ev));
    check("done",      32'(done),      32'(m_done));
    check("wr_err",    32'(wr_err),    32'(m_err));
    obs_valid = out_valid;
    obs_busy  = busy;
    obs_done  = done;
    obs_err   = wr_err;
    if (done === 1'b1) done_seen++;
    if (rst_n && out_valid === 1'b1 && out_ready) got_q.push_back(out_data);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic write_block(input logic [BIT_W-1:0] base, input bit rnd);
    for (int i = 0; i < N; i++) begin
      wr_en   = 1'b1;
      wr_addr = IDX_W'(i);
      wr_data = rnd ? BIT_W'($urandom) : base + BIT_W'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1,0,0 pattern, 2: random ready.
  // chain: raise commit in the cycle the model expects done.
  task automatic run_until_done(input int mode, input bit noise, input bit chain);
    int start;
    int c;
    start = done_seen;
    c = 0;
    while (done_seen == start && c < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = IDX_W'($urandom_range(0, 15));
        wr_data = BIT_W'($urandom);
        commit  = !m_done && ($urandom_range(0, 7) == 0);
      end
      if (chain) commit = m_done;
      tick();
      c++;
    end
    wr_en  = 1'b0;
    commit = 1'b0;
    check("done_pulse_count", 32'(done_seen - start), 32'd1);
  endtask

  task automatic check_block(input string name, input int offs, input logic [BIT_W-1:0] base);
    for (int i = 0; i < N; i++) begin
      if (offs + i < got_q.size())
        check(name, 32'(got_q[offs + i]), 32'(base + BIT_W'(i)));
      else
        check({name, "_missing"}, 32'(got_q.size()), 32'(offs + i + 1));
    end
  endtask

  // Main sequence
  initial begin
    int start;
    int c;
    tbl[0] = '{1'b1, 4'd0,  16'h0100, 1'b0};
    tbl[1] = '{1'b1, 4'd9,  16'h0109, 1'b0};
    tbl[2] = '{1'b1, 4'd10, 16'hBAD0, 1'b1};
    tbl[3] = '{1'b1, 4'd12, 16'hBAD1, 1'b1};
    tbl[4] = '{1'b1, 4'd15, 16'hBAD2, 1'b1};
    tbl[5] = '{1'b0, 4'd12, 16'hBAD3, 1'b0};
    tbl[6] = '{1'b1, 4'd3,  16'h0103, 1'b0};

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_step();
    tick();                        // reset-state comparisons via model
    rst_n = 1'b1;
    tick();

    // Test 1: basic block, ready held high
    write_block(16'h0100, 1'b0);
    got_q.delete();
    do_commit();
    run_until_done(0, 1'b0, 1'b0);
    check("t1_beats", 32'(got_q.size()), 32'(BEATS));
    check_block("t1_data", 0, 16'h0100);
`ifdef UNLOAD_CHECKSUM_EN
    if (got_q.size() > N) check("t1_checksum", 32'(got_q[N]), 32'h0A2D);
`endif
    out_ready = 1'b0;
    tick();
    check("t1_busy_after", 32'(obs_busy), 32'd0);

    // Test 2: same data, stalling ready
    got_q.delete();
    do_commit();
    run_until_done(1, 1'b0, 1'b0);
    check("t2_beats", 32'(got_q.size()), 32'(BEATS));
    check_block("t2_data", 0, 16'h0100);

    // Test 3: write error table in IDLE, then bad write / commit mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_en = tbl[i].en;
      wr_addr = tbl[i].addr;
      wr_data = tbl[i].data;
      tick();
      wr_en = 1'b0;
      tick();
      check("t3_tbl_wr_err", 32'(obs_err), 32'(tbl[i].exp_err));
    end
    got_q.delete();
    do_commit();
    out_ready = 1'b1;
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hDEAD;
    tick();
    wr_en = 1'b0; commit = 1'b1;
    tick();
    check("t3_stream_wr_err", 32'(obs_err), 32'd1);
    commit = 1'b0;
    run_until_done(0, 1'b0, 1'b0);
    check("t3_beats", 32'(got_q.size()), 32'(BEATS));
    check_block("t3_data", 0, 16'h0100);

    // Test 4: reset after four accepted beats
    write_block(16'h0300, 1'b0);
    got_q.delete();
    do_commit();
    out_ready = 1'b1;
    c = 0;
    while (got_q.size() < 4 && c < 50) begin
      tick();
      c++;
    end
    check("t4_partial", 32'(got_q.size()), 32'd4);
    start = done_seen;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_valid_after_rst", 32'(obs_valid), 32'd0);
    check("t4_busy_after_rst", 32'(obs_busy), 32'd0);
    tick();
    check("t4_no_done", 32'(done_seen - start), 32'd0);
    write_block(16'h0400, 1'b0);
    got_q.delete();
    do_commit();
    run_until_done(2, 1'b0, 1'b0);
    check("t4_beats", 32'(got_q.size()), 32'(BEATS));
    check_block("t4_data", 0, 16'h0400);

    // Test 5: commit in the done cycle chains a second block
    write_block(16'h0200, 1'b0);
    got_q.delete();
    do_commit();
    run_until_done(0, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    check("t5_no_gap", 32'(obs_valid), 32'd1);
    run_until_done(0, 1'b0, 1'b0);
    check("t5_beats", 32'(got_q.size()), 32'(2 * BEATS));
    check_block("t5_blk1", 0, 16'h0200);
    check_block("t5_blk2", BEATS, 16'h0200);

    // Randomized blocks with noise against the model
    for (int b = 0; b < 12; b++) begin
      out_ready = 1'b0;
      write_block('0, 1'b1);
      for (int k = 0; k < 6; k++) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = IDX_W'($urandom_range(0, 15));
        wr_data = BIT_W'($urandom);
        tick();
      end
      wr_en = 1'b0;
      do_commit();
      run_until_done(2, 1'b1, 1'b0);
    end

    out_ready = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
